// File: rtl/stepper_motion_profile.sv
// Trapezoidal step-pulse generator: ramps the step period from START_PERIOD down to
// MIN_PERIOD and back so the move ends at the same slow rate it started from.
module stepper_motion_profile #(
  parameter int PERIOD_W     = 20,
  parameter int COUNT_W      = 16,
  parameter int START_PERIOD = 50000,
  parameter int MIN_PERIOD   = 5000,
  parameter int ACCEL_STEP   = 500
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COUNT_W-1:0] cmd_steps,
  input  logic               cmd_dir,
  input  logic               abort,
  output logic               step,
  output logic               direction,
  output logic               motor_enable,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] steps_remaining
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam logic [PERIOD_W:0] START_X = (PERIOD_W+1)'(START_PERIOD);
  localparam logic [PERIOD_W:0] MIN_X   = (PERIOD_W+1)'(MIN_PERIOD);
  localparam logic [PERIOD_W:0] ACC_X   = (PERIOD_W+1)'(ACCEL_STEP);

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d, timer_q, timer_d;
  logic [COUNT_W-1:0]  rem_q, rem_d, ramp_q, ramp_d, r;
  logic                dir_q, dir_d, en_q, en_d, step_q, step_d;
  logic                done_q, done_d, busy_q, busy_d;
  logic [PERIOD_W:0]   p_up, p_dn;
  logic [PERIOD_W-1:0] p_up_sat, p_dn_sat;

  // One extra bit so saturation compares never see a wrapped sum/difference
  assign p_up     = {1'b0, period_q} + ACC_X;
  assign p_dn     = {1'b0, period_q} - ACC_X;
  assign p_up_sat = (p_up > START_X) ? START_X[PERIOD_W-1:0] : p_up[PERIOD_W-1:0];
  assign p_dn_sat = (p_dn[PERIOD_W] || p_dn < MIN_X) ? MIN_X[PERIOD_W-1:0] : p_dn[PERIOD_W-1:0];
  assign r        = rem_q - COUNT_W'(1);

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    timer_d  = timer_q;
    rem_d    = rem_q;
    ramp_d   = ramp_q;
    dir_d    = dir_q;
    en_d     = en_q;
    step_d   = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        dir_d = cmd_dir;
        if (cmd_steps != '0) begin
          state_d  = RUN;
          en_d     = 1'b1;
          period_d = START_X[PERIOD_W-1:0];
          timer_d  = START_X[PERIOD_W-1:0] - PERIOD_W'(1);
          rem_d    = cmd_steps;
          ramp_d   = '0;
        end else begin
          state_d = STOP;
        end
      end
      RUN: begin
        // Final step was issued last cycle; STOP now so done trails that step
        if (rem_q == '0) begin
          state_d = STOP;
        end else if (timer_q == '0) begin
          step_d = 1'b1;
          if (r == '0) begin
            period_d = period_q;
          end else if (r <= ramp_q) begin
            period_d = p_up_sat;
            ramp_d   = (ramp_q == '0) ? '0 : ramp_q - COUNT_W'(1);
          end else if ({1'b0, period_q} > MIN_X) begin
            period_d = p_dn_sat;
            ramp_d   = ramp_q + COUNT_W'(1);
          end
          rem_d   = r;
          timer_d = period_d - PERIOD_W'(1);
          if (abort) rem_d = (r < ramp_d) ? r : ramp_d;
        end else begin
          timer_d = timer_q - PERIOD_W'(1);
          if (abort) begin
            rem_d = (rem_q < ramp_q) ? rem_q : ramp_q;
            if (rem_d == '0) state_d = STOP;
          end
        end
      end
      STOP: begin
        state_d = IDLE;
        en_d    = 1'b0;
        ramp_d  = '0;
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == STOP);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      period_q <= '0;
      timer_q  <= '0;
      rem_q    <= '0;
      ramp_q   <= '0;
      dir_q    <= 1'b0;
      en_q     <= 1'b0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      timer_q  <= timer_d;
      rem_q    <= rem_d;
      ramp_q   <= ramp_d;
      dir_q    <= dir_d;
      en_q     <= en_d;
      step_q   <= step_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign cmd_ready       = (state_q == IDLE);
  assign step            = step_q;
  assign direction       = dir_q;
  assign motor_enable    = en_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign steps_remaining = rem_q;

endmodule

// File: tb/tb_stepper_motion_profile.sv
// Directed bench for stepper_motion_profile using START=8, MIN=2, ACCEL=2.
module tb_stepper_motion_profile;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_steps = '0;
  logic        cmd_dir = 1'b0;
  logic        abort = 1'b0;
  logic        step, direction, motor_enable, busy, done;
  logic [15:0] steps_remaining;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc;
  int st[$];
  int done_cyc;
  int rem_ab;
  logic dir_bad, en_bad, en_at_done, en_ever;

  stepper_motion_profile #(
    .PERIOD_W(20), .COUNT_W(16), .START_PERIOD(8), .MIN_PERIOD(2), .ACCEL_STEP(2)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .abort(abort), .step(step),
    .direction(direction), .motor_enable(motor_enable), .busy(busy), .done(done),
    .steps_remaining(steps_remaining)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic start(input logic [15:0] n, input logic d);
    cmd_steps = n; cmd_dir = d; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic watch(input int budget, input int abort_at, input int stop_at, input logic exp_dir);
    st.delete(); done_cyc = -1; rem_ab = -1;
    dir_bad = 1'b0; en_bad = 1'b0; en_at_done = 1'b0; en_ever = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (abort) begin abort = 1'b0; rem_ab = steps_remaining; end
      if (motor_enable) en_ever = 1'b1;
      if (step) begin
        st.push_back(cyc);
        if (!motor_enable) en_bad = 1'b1;
        if (st.size() == abort_at) abort = 1'b1;
      end
      if (busy && direction !== exp_dir) dir_bad = 1'b1;
      if (done) begin done_cyc = cyc; en_at_done = motor_enable; break; end
      if (stop_at > 0 && st.size() == stop_at) break;
    end
  endtask

  task automatic check_intervals(input string name, input int n, input int e[10]);
    int prev, got;
    tests++;
    if (st.size() != n) begin
      fails++; $display("FAIL %s step_count got %0d want %0d", name, st.size(), n);
    end
    prev = acc;
    for (int k = 0; k < n; k++) begin
      got = (k < st.size()) ? st[k] - prev : -1;
      if (k < st.size()) prev = st[k];
      tests++;
      if (got !== e[k]) begin
        fails++; $display("FAIL %s interval[%0d] got %0d want %0d", name, k, got, e[k]);
      end
    end
  endtask

  task automatic check_end(input string name, input logic exp_en);
    int last;
    last = (st.size() > 0) ? st[st.size()-1] : acc;
    tests++;
    if (done_cyc !== last + 1) begin
      fails++; $display("FAIL %s done_cycle got %0d want %0d", name, done_cyc, last + 1);
    end
    tests++;
    if ({dir_bad, en_bad, en_at_done} !== {1'b0, 1'b0, exp_en}) begin
      fails++; $display("FAIL %s dir_bad/en_bad/en_at_done got %b want 00%b", name,
                        {dir_bad, en_bad, en_at_done}, exp_en);
    end
    @(negedge clk);
    tests++;
    if ({motor_enable, done, busy, cmd_ready} !== 4'b0001) begin
      fails++; $display("FAIL %s after_done en/done/busy/ready got %b want 0001", name,
                        {motor_enable, done, busy, cmd_ready});
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({step, done, motor_enable, direction, busy, steps_remaining, cmd_ready} !== {5'b0, 16'd0, 1'b1}) begin
      fails++; $display("FAIL reset_state got %b want %b",
        {step, done, motor_enable, direction, busy, steps_remaining, cmd_ready}, {5'b0, 16'd0, 1'b1});
    end
  endtask

  task automatic test_full_move;
    int e[10];
    e = '{8, 6, 4, 2, 2, 2, 2, 4, 6, 8};
    start(16'd10, 1'b1);
    watch(300, 0, 0, 1'b1);
    check_intervals("full_move", 10, e);
    check_end("full_move", 1'b1);
  endtask

  task automatic test_abort;
    int e[10];
    e = '{8, 6, 4, 2, 4, 6, 0, 0, 0, 0};
    start(16'd10, 1'b1);
    watch(300, 3, 0, 1'b1);
    tests++;
    if (rem_ab !== 3) begin
      fails++; $display("FAIL abort remaining got %0d want 3", rem_ab);
    end
    check_intervals("abort", 6, e);
    check_end("abort", 1'b1);
  endtask

  task automatic test_zero_steps;
    start(16'd0, 1'b0);
    tests++;
    if ({busy, done, motor_enable, step, direction} !== 5'b11000) begin
      fails++; $display("FAIL zero_steps stop_cycle busy/done/en/step/dir got %b want 11000",
                        {busy, done, motor_enable, step, direction});
    end
    @(negedge clk);
    tests++;
    if ({busy, done, motor_enable, step, cmd_ready} !== 5'b00001) begin
      fails++; $display("FAIL zero_steps after busy/done/en/step/ready got %b want 00001",
                        {busy, done, motor_enable, step, cmd_ready});
    end
  endtask

  task automatic test_single_step;
    int e[10];
    e = '{8, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    start(16'd1, 1'b0);
    watch(100, 0, 0, 1'b0);
    check_intervals("single_step", 1, e);
    check_end("single_step", 1'b1);
  endtask

  task automatic test_reset_mid_run;
    int e[10];
    e = '{8, 6, 8, 0, 0, 0, 0, 0, 0, 0};
    start(16'd10, 1'b0);
    watch(300, 0, 5, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if ({step, done, motor_enable, direction, busy, steps_remaining, cmd_ready} !== {5'b0, 16'd0, 1'b1}) begin
      fails++; $display("FAIL reset_mid_run got %b want %b",
        {step, done, motor_enable, direction, busy, steps_remaining, cmd_ready}, {5'b0, 16'd0, 1'b1});
    end
    start(16'd3, 1'b1);
    watch(200, 0, 0, 1'b1);
    check_intervals("after_reset", 3, e);
    check_end("after_reset", 1'b1);
  endtask

  task automatic test_back_to_back;
    int e[10];
    e = '{8, 6, 8, 0, 0, 0, 0, 0, 0, 0};
    start(16'd3, 1'b0);
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd1;
    watch(200, 0, 0, 1'b0);
    check_intervals("held_valid", 3, e);
    tests++;
    if ({done, dir_bad, direction} !== 3'b100) begin
      fails++; $display("FAIL held_valid done/dir_bad/dir got %b want 100", {done, dir_bad, direction});
    end
    @(negedge clk);
    tests++;
    if ({cmd_ready, busy, direction} !== 3'b100) begin
      fails++; $display("FAIL held_valid idle ready/busy/dir got %b want 100", {cmd_ready, busy, direction});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    acc = cyc;
    tests++;
    if ({busy, direction, steps_remaining} !== {2'b11, 16'd1}) begin
      fails++; $display("FAIL held_valid accept busy/dir/rem got %b want %b",
                        {busy, direction, steps_remaining}, {2'b11, 16'd1});
    end
    watch(100, 0, 0, 1'b1);
    e = '{8, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_intervals("second_cmd", 1, e);
    check_end("second_cmd", 1'b1);
  endtask

  initial begin
    test_reset;
    test_full_move;
    test_abort;
    test_zero_steps;
    test_single_step;
    test_reset_mid_run;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
